// File: rtl/hsv_frame_streamer.sv
// hsv_frame_streamer: walks an image ROM in row-major order, converts each
// RGB888 pixel to HSV (H 0..359, S/V 0..100) through a two-stage pipeline and
// presents one pixel per beat on a valid/ready stream with x/y and frame markers.
module hsv_frame_streamer #(
    parameter int WIDTH      = 400,
    parameter int HEIGHT     = 400,
    parameter int ADDR_W     = 18,
    parameter int X_W        = 9,
    parameter int Y_W        = 9,
    parameter int CONTINUOUS = 0
) (
    input  logic              CLK,
    input  logic              Reset_0,
    input  logic              start,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [23:0]       mem_rgb,
    output logic              out_valid,
    output logic [8:0]        H,
    output logic [6:0]        S,
    output logic [6:0]        V,
    output logic [23:0]       rgb_out,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic              sof,
    output logic              eol,
    output logic              eof,
    output logic              busy,
    output logic              done,
    output logic [7:0]        frame_cnt
);

    localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN} state_t;

    state_t           r_state;
    logic [X_W-1:0]   r_fx;
    logic [Y_W-1:0]   r_fy;
    logic [2:1]       r_vld_pipe;

    // stage-1 registers
    logic [23:0]      r1_rgb;
    logic [7:0]       r1_max;
    logic [7:0]       r1_delta;
    logic [1:0]       r1_sel;      // 0: max is R, 1: G, 2: B
    logic [X_W-1:0]   r1_x;
    logic [Y_W-1:0]   r1_y;
    logic             r1_sof, r1_eol, r1_eof;

    logic             w_en, w_issue, w_last, w_acc_eof;
    logic [7:0]       w_r, w_g, w_b, w_max, w_min;
    logic [1:0]       w_sel;
    logic [7:0]       w1_r, w1_g, w1_b, w_a, w_bb, w_diff;
    logic signed [11:0] w_base, w_h;
    logic [6:0]       w_t;

    // Everything advances together; a stalled output beat freezes the whole chain.
    assign w_en      = !r_vld_pipe[2] || out_ready;
    assign w_issue   = (r_state == ST_FETCH) && w_en;
    assign w_last    = (r_fx == X_LAST) && (r_fy == Y_LAST);
    assign w_acc_eof = r_vld_pipe[2] && out_ready && eof;
    assign out_valid = r_vld_pipe[2];

    // Max/min with R > G > B priority on ties, so the hue base is deterministic.
    assign w_r   = mem_rgb[23:16];
    assign w_g   = mem_rgb[15:8];
    assign w_b   = mem_rgb[7:0];
    assign w_sel = (w_r >= w_g && w_r >= w_b) ? 2'd0 : ((w_g >= w_b) ? 2'd1 : 2'd2);
    assign w_max = (w_sel == 2'd0) ? w_r : ((w_sel == 2'd1) ? w_g : w_b);
    assign w_min = (w_r <= w_g && w_r <= w_b) ? w_r : ((w_g <= w_b) ? w_g : w_b);

    // Control FSM: fetch address/coordinates, busy/done handshake, frame counter.
    always_ff @(posedge CLK or negedge Reset_0) begin
        if (!Reset_0) begin
            r_state   <= ST_IDLE;
            mem_addr  <= '0;
            r_fx      <= '0;
            r_fy      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (w_acc_eof)
                frame_cnt <= frame_cnt + 8'd1;
            case (r_state)
                ST_IDLE: begin
                    // a start coinciding with the done pulse is deliberately dropped
                    if (start && !done) begin
                        r_state  <= ST_FETCH;
                        busy     <= 1'b1;
                        mem_addr <= '0;
                        r_fx     <= '0;
                        r_fy     <= '0;
                    end
                end
                ST_FETCH: begin
                    if (w_en) begin
                        if (w_last) begin
                            mem_addr <= '0;
                            r_fx     <= '0;
                            r_fy     <= '0;
                            if (CONTINUOUS == 0)
                                r_state <= ST_DRAIN;
                        end else begin
                            mem_addr <= mem_addr + ADDR_W'(1);
                            if (r_fx == X_LAST) begin
                                r_fx <= '0;
                                r_fy <= r_fy + Y_W'(1);
                            end else begin
                                r_fx <= r_fx + X_W'(1);
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_acc_eof) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Valid shift register: bit 1 = stage 1, bit 2 = output stage.
    always_ff @(posedge CLK or negedge Reset_0) begin
        if (!Reset_0)
            r_vld_pipe <= '0;
        else if (w_en)
            r_vld_pipe <= {r_vld_pipe[1], w_issue};
    end

    // Stage 1: capture the ROM pixel with its extrema and coordinates.
    always_ff @(posedge CLK or negedge Reset_0) begin
        if (!Reset_0) begin
            r1_rgb   <= '0;
            r1_max   <= '0;
            r1_delta <= '0;
            r1_sel   <= '0;
            r1_x     <= '0;
            r1_y     <= '0;
            r1_sof   <= 1'b0;
            r1_eol   <= 1'b0;
            r1_eof   <= 1'b0;
        end else if (w_issue) begin
            r1_rgb   <= mem_rgb;
            r1_max   <= w_max;
            r1_delta <= w_max - w_min;
            r1_sel   <= w_sel;
            r1_x     <= r_fx;
            r1_y     <= r_fy;
            r1_sof   <= (r_fx == '0) && (r_fy == '0);
            r1_eol   <= (r_fx == X_LAST);
            r1_eof   <= w_last;
        end
    end

    // Hue: pick (base, a, b) by max channel, offset by 60*|a-b|/delta, fold into 0..359.
    always_comb begin
        w1_r   = r1_rgb[23:16];
        w1_g   = r1_rgb[15:8];
        w1_b   = r1_rgb[7:0];
        w_a    = w1_g;
        w_bb   = w1_b;
        w_base = 12'sd0;
        case (r1_sel)
            2'd0:    begin w_a = w1_g; w_bb = w1_b; w_base = 12'sd0;   end
            2'd1:    begin w_a = w1_b; w_bb = w1_r; w_base = 12'sd120; end
            default: begin w_a = w1_r; w_bb = w1_g; w_base = 12'sd240; end
        endcase
        w_diff = (w_a >= w_bb) ? (w_a - w_bb) : (w_bb - w_a);
        w_t    = (r1_delta == 8'd0) ? 7'd0
               : 7'((16'(w_diff) * 16'd60) / 16'(r1_delta));
        w_h    = (w_a >= w_bb) ? (w_base + $signed({5'd0, w_t}))
                               : (w_base - $signed({5'd0, w_t}));
        if (w_h < 12'sd0)
            w_h = w_h + 12'sd360;
        else if (w_h >= 12'sd360)
            w_h = w_h - 12'sd360;
        if (r1_delta == 8'd0)
            w_h = 12'sd0;
    end

    // Stage 2: HSV results and beat sidebands, driven straight onto the outputs.
    always_ff @(posedge CLK or negedge Reset_0) begin
        if (!Reset_0) begin
            H       <= '0;
            S       <= '0;
            V       <= '0;
            rgb_out <= '0;
            x       <= '0;
            y       <= '0;
            sof     <= 1'b0;
            eol     <= 1'b0;
            eof     <= 1'b0;
        end else if (w_en) begin
            H       <= w_h[8:0];
            S       <= (r1_delta == 8'd0) ? 7'd0
                     : 7'((16'(r1_delta) * 16'd100) / 16'(r1_max));
            V       <= 7'((16'(r1_max) * 16'd100) / 16'd255);
            rgb_out <= r1_rgb;
            x       <= r1_x;
            y       <= r1_y;
            sof     <= r_vld_pipe[1] && r1_sof;
            eol     <= r_vld_pipe[1] && r1_eol;
            eof     <= r_vld_pipe[1] && r1_eof;
        end
    end

endmodule

// File: tb/tb_hsv_frame_streamer.sv
// Directed bench for hsv_frame_streamer on a 4x3 frame: single-frame and
// continuous instances, backpressure, mid-frame reset and held start.
module tb_hsv_frame_streamer;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [23:0] rom [16];
    int          exp_h [12];
    int          exp_s [12];
    int          exp_v [12];

    // single-frame instance
    logic        a_rst_n, a_start, a_ready;
    logic [3:0]  a_addr;
    logic [23:0] a_rgb, a_rgb_out;
    logic        a_valid, a_sof, a_eol, a_eof, a_busy, a_done;
    logic [8:0]  a_h;
    logic [6:0]  a_s, a_v;
    logic [1:0]  a_x, a_y;
    logic [7:0]  a_fc;

    // continuous instance
    logic        b_rst_n, b_start, b_ready;
    logic [3:0]  b_addr;
    logic [23:0] b_rgb, b_rgb_out;
    logic        b_valid, b_sof, b_eol, b_eof, b_busy, b_done;
    logic [8:0]  b_h;
    logic [6:0]  b_s, b_v;
    logic [1:0]  b_x, b_y;
    logic [7:0]  b_fc;

    assign a_rgb = rom[a_addr];
    assign b_rgb = rom[b_addr];

    hsv_frame_streamer #(.WIDTH(4), .HEIGHT(3), .ADDR_W(4), .X_W(2), .Y_W(2), .CONTINUOUS(0)) u_a (
        .CLK(CLK), .Reset_0(a_rst_n), .start(a_start), .out_ready(a_ready),
        .mem_addr(a_addr), .mem_rgb(a_rgb), .out_valid(a_valid),
        .H(a_h), .S(a_s), .V(a_v), .rgb_out(a_rgb_out), .x(a_x), .y(a_y),
        .sof(a_sof), .eol(a_eol), .eof(a_eof), .busy(a_busy), .done(a_done),
        .frame_cnt(a_fc));

    hsv_frame_streamer #(.WIDTH(4), .HEIGHT(3), .ADDR_W(4), .X_W(2), .Y_W(2), .CONTINUOUS(1)) u_b (
        .CLK(CLK), .Reset_0(b_rst_n), .start(b_start), .out_ready(b_ready),
        .mem_addr(b_addr), .mem_rgb(b_rgb), .out_valid(b_valid),
        .H(b_h), .S(b_s), .V(b_v), .rgb_out(b_rgb_out), .x(b_x), .y(b_y),
        .sof(b_sof), .eol(b_eol), .eof(b_eof), .busy(b_busy), .done(b_done),
        .frame_cnt(b_fc));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Consume one 4x3 frame from u_a; stall=1 applies ready pattern 1,0,0,1,0,1...
    task automatic run_a(input bit stall, input int fc_exp);
        int          n;
        bit          acc, hold;
        bit [5:0]    pat;
        logic [23:0] s_rgb;
        logic [8:0]  s_h;
        logic [3:0]  s_addr;
        logic [1:0]  s_x;
        n    = 0;
        hold = 1'b0;
        pat  = 6'b101001;
        for (int c = 0; c < 200 && n < 12; c++) begin
            a_ready = stall ? pat[c % 6] : 1'b1;
            acc = a_valid && a_ready;
            if (acc) begin
                chk($sformatf("rgb%0d", n), a_rgb_out, rom[n]);
                chk($sformatf("h%0d", n),   a_h, exp_h[n]);
                chk($sformatf("s%0d", n),   a_s, exp_s[n]);
                chk($sformatf("v%0d", n),   a_v, exp_v[n]);
                chk($sformatf("x%0d", n),   a_x, n % 4);
                chk($sformatf("y%0d", n),   a_y, n / 4);
                chk($sformatf("sof%0d", n), a_sof, (n == 0));
                chk($sformatf("eol%0d", n), a_eol, (n % 4 == 3));
                chk($sformatf("eof%0d", n), a_eof, (n == 11));
            end
            if (a_valid && !a_ready) begin
                hold   = 1'b1;
                s_rgb  = a_rgb_out;
                s_h    = a_h;
                s_addr = a_addr;
                s_x    = a_x;
            end
            step();
            if (hold) begin
                chk("hold_valid", a_valid, 1);
                chk("hold_rgb", a_rgb_out, s_rgb);
                chk("hold_h", a_h, s_h);
                chk("hold_x", a_x, s_x);
                chk("hold_addr", a_addr, s_addr);
                hold = 1'b0;
            end
            if (acc) begin
                n++;
                if (n == 12) begin
                    chk("done_pulse", a_done, 1);
                    chk("busy_at_done", a_busy, 0);
                    chk("frame_cnt", a_fc, fc_exp);
                end
            end
        end
        chk("beat_count", n, 12);
        a_ready = 1'b1;
    endtask

    initial begin
        int  n;
        bit  started, found;
        rom = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFF00FF,
                24'hFF8000, 24'h808080, 24'h000000, 24'hFFFF00,
                24'h00FFFF, 24'h102030, 24'hFF0080, 24'h204060,
                24'h0, 24'h0, 24'h0, 24'h0};
        exp_h = '{0, 120, 240, 300, 30, 0, 0, 60, 180, 210, 330, 210};
        exp_s = '{100, 100, 100, 100, 100, 0, 0, 100, 100, 66, 100, 66};
        exp_v = '{100, 100, 100, 100, 100, 50, 0, 100, 100, 18, 100, 37};

        a_rst_n = 1'b0; a_start = 1'b0; a_ready = 1'b1;
        b_rst_n = 1'b0; b_start = 1'b0; b_ready = 1'b1;
        step(); step();

        // reset state
        chk("rst_valid", a_valid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_addr", a_addr, 0);
        chk("rst_fc", a_fc, 0);
        chk("rst_h", a_h, 0);
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        step();

        // frame 1: latency then 12 beats at full rate
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        chk("lat_busy", a_busy, 1);
        chk("lat_valid_k", a_valid, 0);
        chk("lat_addr_k", a_addr, 0);
        step();
        chk("lat_valid_k1", a_valid, 0);
        chk("lat_addr_k1", a_addr, 1);
        step();
        chk("lat_valid_k2", a_valid, 1);
        run_a(1'b0, 1);
        step();
        chk("done_cleared", a_done, 0);

        // frame 2 with backpressure
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        run_a(1'b1, 2);
        step();

        // mid-frame reset during beat 5
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            if (a_valid && a_x == 2'd1 && a_y == 2'd1) found = 1'b1;
            else step();
        end
        chk("beat5_seen", found, 1);
        a_rst_n = 1'b0;
        #1;
        chk("arst_valid", a_valid, 0);
        chk("arst_rgb", a_rgb_out, 0);
        chk("arst_x", a_x, 0);
        chk("arst_y", a_y, 0);
        chk("arst_busy", a_busy, 0);
        chk("arst_addr", a_addr, 0);
        chk("arst_fc", a_fc, 0);
        @(posedge CLK);
        #1;
        a_rst_n = 1'b1;
        step();
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        run_a(1'b0, 1);
        step();

        // start held high: ignored while busy and during done, restarts after
        a_start = 1'b1;
        step();
        run_a(1'b0, 2);
        step();
        chk("start_ign_done", a_busy, 0);
        step();
        chk("start_restart", a_busy, 1);
        chk("restart_addr", a_addr, 0);
        a_start = 1'b0;
        run_a(1'b0, 3);

        // continuous mode: 36 contiguous beats
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        n = 0;
        started = 1'b0;
        for (int c = 0; c < 100 && n < 36; c++) begin
            if (b_valid) begin
                started = 1'b1;
                chk($sformatf("b_rgb%0d", n), b_rgb_out, rom[n % 12]);
                chk($sformatf("b_sof%0d", n), b_sof, (n % 12 == 0));
                chk($sformatf("b_done%0d", n), b_done, 0);
                n++;
            end else if (started) begin
                chk("b_contig", b_valid, 1);
            end
            step();
        end
        chk("b_beats", n, 36);
        chk("b_fc", b_fc, 3);
        chk("b_busy", b_busy, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
